// File: rtl/fetch_unit.sv
// Y86-64 SEQ instruction fetch: byte-serial imem reads, field split, valP/stat.
// Optional FETCH_INSTR_CHECK_EN flags bad icode/ifun as INS after the opcode byte.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc,
  output logic [2:0]  stat
);

  typedef enum logic [2:0] {FETCH0, REGS, CONST, DONE, WAIT_PC, HALTED} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d, pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        ack_ok;
  logic        bad;
  logic [3:0]  op_len;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

`ifdef FETCH_INSTR_CHECK_EN
  function automatic logic instr_bad(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7: instr_bad = (fn > 4'd6);
      4'h6:       instr_bad = (fn > 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF: instr_bad = 1'b1;
      default:    instr_bad = (fn != 4'd0);
    endcase
  endfunction
  assign bad = instr_bad(imem_rdata[7:4], imem_rdata[3:0]);
`else
  assign bad = 1'b0;
`endif

  assign ack_ok    = req_q && imem_ack;
  assign op_len    = len_of(imem_rdata[7:4]);
  assign imem_req  = req_q;
  assign imem_addr = pc_q + {60'd0, idx_q};
  assign f_valid   = (state_q == DONE);
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign pc        = pc_q;
  assign stat      = stat_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    pc_d    = pc_q;
    stat_d  = stat_q;

    // An address fault on any byte ends the fetch; valP counts only bytes read.
    if (ack_ok && imem_err &&
        (state_q == FETCH0 || state_q == REGS || state_q == CONST)) begin
      stat_d  = STAT_ADR;
      valp_d  = pc_q + {60'd0, idx_q};
      req_d   = 1'b0;
      state_d = DONE;
    end else begin
      case (state_q)
        FETCH0: begin
          if (!req_q) begin
            req_d = 1'b1;
          end else if (ack_ok) begin
            icode_d = imem_rdata[7:4];
            ifun_d  = imem_rdata[3:0];
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = '0;
            idx_d   = idx_q + 4'd1;
            if (bad) begin
              stat_d  = STAT_INS;
              valp_d  = pc_q + 64'd1;
              req_d   = 1'b0;
              state_d = DONE;
            end else begin
              stat_d = (imem_rdata[7:4] == 4'h0) ? STAT_HLT : STAT_AOK;
              valp_d = pc_q + {60'd0, op_len};
              if (op_len == 4'd1) begin
                req_d   = 1'b0;
                state_d = DONE;
              end else if (imem_rdata[7:4] == 4'h7 || imem_rdata[7:4] == 4'h8) begin
                cnt_d   = '0;
                state_d = CONST;
              end else begin
                state_d = REGS;
              end
            end
          end
        end
        REGS: begin
          if (ack_ok) begin
            ra_d  = imem_rdata[7:4];
            rb_d  = imem_rdata[3:0];
            idx_d = idx_q + 4'd1;
            if (icode_q == 4'h3 || icode_q == 4'h4 || icode_q == 4'h5) begin
              cnt_d   = '0;
              state_d = CONST;
            end else begin
              req_d   = 1'b0;
              state_d = DONE;
            end
          end
        end
        CONST: begin
          if (ack_ok) begin
            valc_d[{cnt_q[2:0], 3'b000} +: 8] = imem_rdata;
            cnt_d = cnt_q + 4'd1;
            idx_d = idx_q + 4'd1;
            if (cnt_q == 4'd7) begin
              req_d   = 1'b0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (f_ready) begin
            if (stat_q != STAT_AOK) begin
              state_d = HALTED;
            end else if (pc_load) begin
              pc_d    = pc_in;
              idx_d   = '0;
              req_d   = 1'b1;
              state_d = FETCH0;
            end else begin
              state_d = WAIT_PC;
            end
          end
        end
        WAIT_PC: begin
          if (pc_load) begin
            pc_d    = pc_in;
            idx_d   = '0;
            req_d   = 1'b1;
            state_d = FETCH0;
          end
        end
        HALTED: begin
          req_d = 1'b0;
        end
        default: begin
          state_d = FETCH0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH0;
      idx_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= '0;
      pc_q    <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
    end
  end

endmodule
